// File: rtl/pc_hazard_ctrl.sv
// PC / pipeline hazard controller: redirect, jump, load-use stall and
// instruction-memory wait handling with saturating event counters.
module pc_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_taken_mem,
    input  logic        jump_id,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic [4:0]  if_id_rs,
    input  logic [4:0]  if_id_rt,
    input  logic        if_id_uses_rt,
    input  logic        imem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        jump,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        ex_mem_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        WAIT     = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        hazard;
    logic        stall_inc, flush_inc;

    assign hazard = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                    ((id_ex_rt == if_id_rs) ||
                     (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_comb begin
        state_d      = state_q;
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        jump         = 1'b0;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        if (!rst || state_q == BOOT) begin
            // Reset holds outputs at BOOT values even before the first edge
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = RUN;
        end else if (branch_taken_mem) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_flush = 1'b1;
            flush_inc    = 1'b1;
            state_d      = REDIRECT;
        end else if (jump_id && state_q != REDIRECT) begin
            jump        = 1'b1;
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
            state_d     = RUN;
        end else if (hazard && state_q != REDIRECT) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            stall_inc    = 1'b1;
        end else if (!imem_ready) begin
            // Bubble into ID while the rest of the pipe keeps draining
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            state_d     = WAIT;
        end else begin
            state_d = RUN;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        if (flush_inc && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= BOOT;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Directed self-checking bench for pc_hazard_ctrl.
module tb_pc_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_taken_mem;
    logic        jump_id;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rt;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        if_id_uses_rt;
    logic        imem_ready;
    logic        pc_write;
    logic        pc_src;
    logic        jump;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic        ex_mem_flush;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int checks   = 0;
    int failures = 0;

    pc_hazard_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .branch_taken_mem (branch_taken_mem),
        .jump_id          (jump_id),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rt         (id_ex_rt),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .if_id_uses_rt    (if_id_uses_rt),
        .imem_ready       (imem_ready),
        .pc_write         (pc_write),
        .pc_src           (pc_src),
        .jump             (jump),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .ex_mem_flush     (ex_mem_flush),
        .stall_cnt        (stall_cnt),
        .flush_cnt        (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ctl = {pc_write,pc_src,jump,if_id_write,if_id_flush,id_ex_bubble,ex_mem_flush}
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, pc_write, pc_src, jump, if_id_write,
                  if_id_flush, id_ex_bubble, ex_mem_flush}, {25'd0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_in();
        branch_taken_mem = 1'b0;
        jump_id          = 1'b0;
        id_ex_mem_read   = 1'b0;
        id_ex_rt         = 5'd0;
        if_id_rs         = 5'd0;
        if_id_rt         = 5'd0;
        if_id_uses_rt    = 1'b0;
        imem_ready       = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        tick();
        tick();
        chk_ctl("reset_ctl", 7'b0001111);
        chk("reset_stall", {16'd0, stall_cnt}, 32'd0);
        chk("reset_flush", {16'd0, flush_cnt}, 32'd0);

        rst = 1'b1;
        settle();
        chk_ctl("boot_ctl", 7'b0001111);
        tick();
        chk_ctl("run_default", 7'b1001000);
        chk("run_counters", {stall_cnt, flush_cnt}, 32'd0);

        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd5;
        if_id_rs = 5'd5;
        settle();
        chk_ctl("hazard_rs_ctl", 7'b0000010);
        tick();
        chk("hazard_rs_cnt", {16'd0, stall_cnt}, 32'd1);

        id_ex_rt = 5'd0;
        if_id_rs = 5'd0;
        settle();
        chk_ctl("hazard_r0_ctl", 7'b1001000);
        tick();
        chk("hazard_r0_cnt", {16'd0, stall_cnt}, 32'd1);

        id_ex_rt = 5'd7;
        if_id_rs = 5'd3;
        if_id_rt = 5'd7;
        settle();
        chk_ctl("rt_unused_ctl", 7'b1001000);
        if_id_uses_rt = 1'b1;
        settle();
        chk_ctl("rt_used_ctl", 7'b0000010);
        tick();
        chk("rt_used_cnt", {16'd0, stall_cnt}, 32'd2);

        branch_taken_mem = 1'b1;
        jump_id = 1'b1;
        settle();
        chk_ctl("branch_prio_ctl", 7'b1101111);
        tick();
        chk("branch_prio_cnt", {stall_cnt, flush_cnt}, {16'd2, 16'd1});

        branch_taken_mem = 1'b0;
        settle();
        chk_ctl("redirect_mask_ctl", 7'b1001000);
        tick();
        chk("redirect_mask_cnt", {stall_cnt, flush_cnt}, {16'd2, 16'd1});

        id_ex_mem_read = 1'b0;
        settle();
        chk_ctl("jump_ctl", 7'b1011100);
        tick();
        chk("jump_cnt", {16'd0, flush_cnt}, 32'd2);

        idle_in();
        imem_ready = 1'b0;
        settle();
        chk_ctl("miss1_ctl", 7'b0001100);
        tick();
        chk_ctl("miss2_ctl", 7'b0001100);
        tick();
        chk_ctl("miss3_ctl", 7'b0001100);
        tick();
        imem_ready = 1'b1;
        settle();
        chk_ctl("wait_exit_ctl", 7'b1001000);
        tick();
        chk_ctl("after_wait_ctl", 7'b1001000);

        imem_ready = 1'b0;
        settle();
        chk_ctl("miss_a_ctl", 7'b0001100);
        tick();
        branch_taken_mem = 1'b1;
        settle();
        chk_ctl("wait_branch_ctl", 7'b1101111);
        tick();
        chk("wait_branch_cnt", {16'd0, flush_cnt}, 32'd3);
        branch_taken_mem = 1'b0;
        imem_ready = 1'b1;
        jump_id = 1'b1;
        settle();
        chk_ctl("redir2_mask_ctl", 7'b1001000);
        tick();
        chk("redir2_cnt", {16'd0, flush_cnt}, 32'd3);

        idle_in();
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd9;
        if_id_rs = 5'd9;
        for (int i = 0; i < 65537; i++) tick();
        chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
        tick();
        chk("stall_sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

        idle_in();
        imem_ready = 1'b0;
        tick();
        chk_ctl("pre_rst_wait_ctl", 7'b0001100);
        rst = 1'b0;
        settle();
        chk_ctl("mid_rst_ctl", 7'b0001111);
        tick();
        chk("mid_rst_cnt", {stall_cnt, flush_cnt}, 32'd0);
        rst = 1'b1;
        imem_ready = 1'b1;
        settle();
        chk_ctl("reboot_ctl", 7'b0001111);
        tick();
        chk_ctl("rerun_ctl", 7'b1001000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_hazard_ctrl.md
PC_HAZARD_CTRL -- requirements
Module: pc_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have ports: rst  in  1  synchronous, active-low reset, sampled on the rising clk edge.
REQ-003 SHALL have ports: branch_taken_mem  in  1  branch resolved taken in MEM (drives PC redirect to PC_MEM+1).
REQ-004 SHALL have ports: jump_id  in  1  jump decoded in ID.
REQ-005 SHALL have ports: id_ex_mem_read  in  1  instruction in EX is a load.
REQ-006 SHALL have ports: id_ex_rt  in  5  load destination register.
REQ-007 SHALL have ports: if_id_rs, if_id_rt  in  5 each  source registers of the instruction in ID; if_id_uses_rt  in  1  ID reads rt.
REQ-008 SHALL have ports: imem_ready  in  1  instruction memory returns valid data this cycle.
REQ-009 SHALL have ports: pc_write  out  1  PC update enable.
REQ-010 SHALL have ports: pc_src  out  1  select PC_MEM+1; jump  out  1  select jump target.
REQ-011 SHALL have ports: if_id_write  out  1;  if_id_flush  out  1;  id_ex_bubble  out  1;  ex_mem_flush  out  1.
REQ-012 SHALL have ports: stall_cnt  out  16  load-use stall cycles; flush_cnt  out  16  redirect events.

Function
REQ-013 SHALL implement FSM states BOOT, RUN, WAIT, REDIRECT; state held in one register; all control outputs combinational from state and inputs; counters registered.
REQ-014 BOOT: pc_write=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; unconditionally -> RUN next cycle.
REQ-015 Priority within RUN/WAIT/REDIRECT, highest first: branch_taken_mem, jump_id, load-use hazard, imem miss.
REQ-016 Branch taken (any non-BOOT state): pc_write=1, pc_src=1, jump=0, if_id_flush=1, id_ex_bubble=1, ex_mem_flush=1; flush_cnt+1; next state REDIRECT.
REQ-017 Jump (jump_id=1, no branch, state not REDIRECT): pc_write=1, jump=1, pc_src=0, if_id_flush=1; flush_cnt+1; next state RUN.
REQ-018 Load-use hazard = id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==if_id_rs | (if_id_uses_rt & id_ex_rt==if_id_rt)).
REQ-019 On hazard (no branch/jump, state not REDIRECT): pc_write=0, if_id_write=0, id_ex_bubble=1; stall_cnt+1; state unchanged.
REQ-020 Imem miss (imem_ready=0, nothing higher): pc_write=0, if_id_write=1, if_id_flush=1 (bubble into ID, downstream advances); next state WAIT.
REQ-021 WAIT exits to RUN in the cycle imem_ready=1 with sequential fetch (pc_write=1, pc_src=0, jump=0).
REQ-022 Branch taken during WAIT overrides the miss: redirect applied per REQ-016; pending fetch discarded.
REQ-023 REDIRECT lasts exactly one cycle: jump_id and hazard inputs masked (ID/EX hold flushed bubbles); imem miss still honoured (-> WAIT) else -> RUN.
REQ-024 Default (RUN, no event): pc_write=1, if_id_write=1, pc_src=0, jump=0, all flush/bubble=0.
REQ-025 pc_src and jump SHALL never both be 1; jump=1 or pc_src=1 only when pc_write=1.
REQ-026 Counters SHALL saturate at 16'hFFFF, never wrap.

Reset
REQ-027 While rst=0: state<=BOOT, stall_cnt<=0, flush_cnt<=0; outputs take BOOT values.
REQ-028 Reset mid-operation (any state, any inputs) SHALL abort pending redirect/wait; first cycle after rst rises is BOOT, second is RUN.

Verification
REQ-029 Release rst; no events, imem_ready=1 -> cycle 1 BOOT (pc_write=0, all flushes=1), cycle 2+ pc_write=1, counters 0.
REQ-030 id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cnt=1; same with id_ex_rt=0 -> no stall.
REQ-031 branch_taken_mem=1 together with jump_id=1 and load-use hazard -> pc_src=1, jump=0, 3 flushes, flush_cnt+1 only; next cycle jump_id=1 ignored (REDIRECT).
REQ-032 imem_ready=0 for 3 cycles then 1 -> pc_write=0 x3 with if_id_flush=1, state WAIT, then pc_write=1 and RUN; branch_taken_mem=1 in 2nd wait cycle -> immediate redirect.
REQ-033 Force 65537 hazard cycles -> stall_cnt holds 16'hFFFF; assert rst=0 mid-WAIT -> counters 0, BOOT then RUN.
